// File: rtl/mem_ctrl_pkg.sv
// Shared types and default geometry for the bitcell-array memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    // Default geometry, shared with the decoder and bitcell-array benches.
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        RELEASE = 3'd3,
        RESP    = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Sequences single read/write requests onto the 3-to-8 decoder and NAND-latch bitcell row.
// Latency: accept at E0, rsp_valid in the cycle after E(N+2), req_ready back after E(N+3).
// Backpressure: req_ready is low in every non-IDLE state; request inputs are ignored while busy.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_select,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic             accept;
    logic             access_last;

    assign accept      = (state == IDLE) && req_valid;
    assign access_last = (state == ACCESS) && (cnt == '0);

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the handshake outputs that follow the current state.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the decoder sees clean,
    // glitch-free select/we edges; select and we always fall together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_select <= 1'b0;
            mem_we     <= 1'b0;
            rsp_valid  <= 1'b0;
        end else begin
            mem_select <= (state_nxt == ACCESS);
            mem_we     <= (state_nxt == ACCESS) && wr_q;
            rsp_valid  <= (state_nxt == RESP);
        end
    end

    // Request latch: address and data move only on the accept edge, so they
    // are settled a full SETUP cycle before select rises and held through RELEASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            wr_q      <= req_write;
            mem_adr   <= req_addr;
            mem_wdata <= req_wdata;
        end
    end

    // Phase counter: loaded in SETUP with N-1, counts down through ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == SETUP) begin
            cnt <= wr_q ? WR_LOAD : RD_LOAD;
        end else if ((state == ACCESS) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Read data is captured on the last ACCESS edge; a write zeroes it on RESP entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
        end else if (access_last && !wr_q) begin
            rsp_rdata <= mem_rdata;
        end else if ((state == RELEASE) && wr_q) begin
            rsp_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural bitcell row model.
// Latency: checks rsp_valid arrives N+2 edges after acceptance.
// Backpressure: checks req_ready is low while busy and busy-time requests are ignored.
module tb_mem_access_ctrl;

    localparam int AW = 3;
    localparam int DW = 4;
    localparam int WR = 2;
    localparam int RD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_adr;
    logic          mem_select;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WR), .RD_CYCLES(RD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_adr(mem_adr), .mem_select(mem_select), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bitcell row model driven by the DUT
    logic [DW-1:0] bits [8];
    assign mem_rdata = bits[mem_adr];
    always @(posedge clk) begin
        if (mem_select && mem_we) bits[mem_adr] <= mem_wdata;
    end

    // Scoreboard
    typedef struct {
        logic [DW-1:0] rdata;
        int            lat;
        int            acc;
    } exp_t;

    exp_t          sb [$];
    exp_t          e_in;
    exp_t          e_out;
    logic [DW-1:0] ref_mem [8];
    int            cyc = 0;
    int            n_acc = 0;
    int            n_rsp = 0;
    int            vectors = 0;
    int            fails = 0;
    logic          prev_sel = 1'b0;
    logic [AW-1:0] prev_adr = '0;

    // Acceptance: reference memory and expected response are produced here
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (req_valid && req_ready) begin
            e_in.acc = cyc;
            e_in.lat = (req_write ? WR : RD) + 3;
            if (req_write) begin
                ref_mem[req_addr] = req_wdata;
                e_in.rdata = '0;
            end else begin
                e_in.rdata = ref_mem[req_addr];
            end
            sb.push_back(e_in);
            n_acc++;
        end
        cyc++;
    end

    // Response and protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                n_rsp++;
                vectors++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: rsp_valid with nothing outstanding, rdata=%h", rsp_rdata);
                end else begin
                    e_out = sb.pop_front();
                    if (rsp_rdata !== e_out.rdata || (cyc - e_out.acc) != e_out.lat) begin
                        fails++;
                        $display("FAIL rsp_data: rdata=%h latency=%0d, expected rdata=%h latency=%0d",
                                 rsp_rdata, cyc - e_out.acc, e_out.rdata, e_out.lat);
                    end
                end
            end
            if (mem_select && prev_sel) begin
                vectors++;
                if (mem_adr !== prev_adr) begin
                    fails++;
                    $display("FAIL adr_stable: mem_adr %b -> %b while select high", prev_adr, mem_adr);
                end
            end
            if (mem_we) begin
                vectors++;
                if (mem_select !== 1'b1) begin
                    fails++;
                    $display("FAIL we_without_select: mem_we=1 mem_select=%b", mem_select);
                end
            end
            prev_sel = mem_select;
            prev_adr = mem_adr;
        end
    end

    // Present one request and return just after the edge that accepted it
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vectors++;
        if (!ok) begin
            fails++;
            $display("FAIL accept_timeout: req_ready=%b, expected 1 within 50 cycles", req_ready);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        vectors++;
        if (!ok) begin
            fails++;
            $display("FAIL idle_timeout: busy=%b, expected 0 within 50 cycles", busy);
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_select !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: ready=%b rsp=%b sel=%b busy=%b, expected 1 0 0 0",
                     req_ready, rsp_valid, mem_select, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 1'b1 || busy !== 1'b0 || mem_select !== 1'b0 || mem_we !== 1'b0 ||
                mem_adr !== 3'b000 || rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle: ready=%b busy=%b sel=%b we=%b adr=%b rsp=%b, expected 1 0 0 0 000 0",
                         req_ready, busy, mem_select, mem_we, mem_adr, rsp_valid);
            end
        end
    endtask

    // Phase k counts falling edges after the accept edge: 0 SETUP, 1..2 ACCESS, 3 RELEASE, 4 RESP, 5 IDLE
    task automatic test_write();
        logic exp_sel;
        issue(1'b1, 3'b101, 4'hA);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_sel = (k == 1 || k == 2);
            vectors++;
            if (mem_select !== exp_sel || mem_we !== exp_sel || mem_adr !== 3'b101 ||
                mem_wdata !== 4'hA || rsp_valid !== (k == 4) || req_ready !== (k == 5)) begin
                fails++;
                $display("FAIL write_phase%0d: sel=%b we=%b adr=%b wd=%h rsp=%b rdy=%b, expected %b %b 101 a %b %b",
                         k, mem_select, mem_we, mem_adr, mem_wdata, rsp_valid, req_ready,
                         exp_sel, exp_sel, (k == 4), (k == 5));
            end
            if (k == 4) begin
                vectors++;
                if (rsp_rdata !== 4'h0) begin
                    fails++;
                    $display("FAIL write_rdata: rsp_rdata=%h, expected 0", rsp_rdata);
                end
            end
        end
    endtask

    task automatic test_read();
        logic exp_sel;
        issue(1'b0, 3'b101, 4'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_sel = (k == 1 || k == 2);
            vectors++;
            if (mem_select !== exp_sel || mem_we !== 1'b0 || mem_adr !== 3'b101 ||
                rsp_valid !== (k == 4) || busy !== (k != 5)) begin
                fails++;
                $display("FAIL read_phase%0d: sel=%b we=%b adr=%b rsp=%b busy=%b, expected %b 0 101 %b %b",
                         k, mem_select, mem_we, mem_adr, rsp_valid, busy, exp_sel, (k == 4), (k != 5));
            end
            if (k == 4) begin
                vectors++;
                if (rsp_rdata !== 4'hA) begin
                    fails++;
                    $display("FAIL read_rdata: rsp_rdata=%h, expected a", rsp_rdata);
                end
            end
        end
    endtask

    task automatic test_sweep();
        logic [AW-1:0] a;
        for (int i = 0; i < 8; i++) begin
            a = AW'(i);
            issue(1'b1, a, {1'b0, a} ^ 4'h5);
            wait_idle();
        end
        for (int i = 0; i < 8; i++) begin
            a = AW'(i);
            issue(1'b0, a, 4'h0);
            wait_idle();
        end
    endtask

    task automatic test_back_to_back();
        int acc0;
        int rsp0;
        wait_idle();
        acc0 = n_acc;
        rsp0 = n_rsp;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 7));
            req_wdata = DW'($urandom_range(0, 15));
            vectors++;
            if (req_ready !== !busy) begin
                fails++;
                $display("FAIL b2b_ready: req_ready=%b busy=%b, expected req_ready=~busy", req_ready, busy);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        vectors++;
        if ((n_acc - acc0) != 6 || (n_rsp - rsp0) != 6 || sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_count: accepts=%0d responses=%0d pending=%0d, expected 6 6 0",
                     n_acc - acc0, n_rsp - rsp0, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int rsp0;
        wait_idle();
        issue(1'b1, 3'b010, 4'h3);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mem_select !== 1'b1 || mem_we !== 1'b1) begin
            fails++;
            $display("FAIL mid_access: sel=%b we=%b, expected 1 1", mem_select, mem_we);
        end
        rsp0 = n_rsp;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_select !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_async_drop: sel=%b we=%b busy=%b, expected 0 0 0", mem_select, mem_we, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (n_rsp != rsp0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_no_rsp: responses=%0d, expected %0d", n_rsp, rsp0);
        end
        issue(1'b1, 3'b010, 4'h9);
        wait_idle();
        issue(1'b0, 3'b010, 4'h0);
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            bits[i]    = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_sweep();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
